// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH register stages, each with its own valid bit, and a
// valid/ready handshake at both ends. Any empty stage takes data from the stage
// behind it even while the output is stalled, so bubbles collapse toward the
// output. A synchronous flush drops every in-flight word.
//
// Handshake: a word moves across an interface on a rising edge exactly when
// valid and ready are both high on that edge. The sender holds valid and data
// steady until that happens. Ready may depend combinationally on the far end.
module pipe_reg_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  occupancy
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];

    // Stage ready. Stage i can load when some stage from i to the end is empty
    // or the output is being taken. Building the term with an accumulator
    // avoids a self-referencing bit vector.
    always_comb begin
        logic hole;
        hole = out_ready;
        r    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hole = hole | ~v[i];
            r[i] = hole & ~flush;
        end
    end

    // Upstream source of each stage. Stage 0 is fed by the input port.
    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    // Stage registers. Data is loaded only from a valid source, so an empty
    // stage keeps its last word, and flush clears the valid bits only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) begin
                        d[i] <= up_d[i];
                    end
                end
            end
        end
    end

    // Number of valid stages.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + CNTW'(v[i]);
        end
    end

    assign in_ready  = r[0];
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (WIDTH=8, DEPTH=3): directed scenarios with literal
// expectations, then random traffic against a queue-of-words reference model.
module tb_pipe_reg_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CNTW  = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNTW-1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words in flight, oldest first, each with the stage index it sits in.
    // A word advances one stage per edge when there is an empty slot anywhere
    // ahead of it or the output is being taken; the oldest word at the last
    // stage leaves when out_ready is high.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               pos;
    } word_t;

    word_t            mq[$];
    word_t            nq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_out = '0;
    bit               m_acc;
    int               m_n;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            exp_q.delete();
            last_out = '0;
        end else if (flush) begin
            mq.delete();
            exp_q.delete();
        end else begin
            m_n   = mq.size();
            m_acc = in_valid && (out_ready || m_n < DEPTH);
            nq.delete();
            for (int k = 0; k < m_n; k++) begin
                word_t w;
                w = mq[k];
                if (out_ready || k < DEPTH - 1 - w.pos) begin
                    if (w.pos == DEPTH - 1) begin
                        void'(exp_q.pop_front());
                        continue;
                    end
                    w.pos = w.pos + 1;
                    if (w.pos == DEPTH - 1) last_out = w.data;
                end
                nq.push_back(w);
            end
            if (m_acc) begin
                word_t w;
                w.data = in_data;
                w.pos  = 0;
                nq.push_back(w);
                exp_q.push_back(in_data);
                if (DEPTH == 1) last_out = in_data;
            end
            mq = nq;
        end
    end

    // ---------------- compare process ----------------
    logic exp_ov;
    always @(negedge clk) begin
        #2;
        exp_ov = !flush && mq.size() > 0 && mq[0].pos == DEPTH - 1;
        check("in_ready", 32'(in_ready), 32'(!flush && (out_ready || mq.size() < DEPTH)));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("out_data", 32'(out_data), 32'(last_out));
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        if (exp_ov && out_ready && exp_q.size() > 0)
            check("order", 32'(out_data), 32'(exp_q[0]));
    end

    // ---------------- driver ----------------
    task automatic drive(input logic iv, input logic [WIDTH-1:0] id,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] bp_words[4];
    int               first_cyc;
    int               nxt;
    int               idx;
    logic [WIDTH-1:0] pend;
    bit               pend_v;

    initial begin
        #1 reset = 1'b0;
        repeat (3) drive(0, '0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_occ", 32'(occupancy), 32'd0);

        // Streaming 0x01..0x10 with out_ready=1
        got.delete();
        first_cyc = -1;
        nxt = 1;
        for (int c = 0; c < 40 && got.size() < 16; c++) begin
            if (nxt <= 16) begin
                drive(1, WIDTH'(nxt), 1, 0);
                check("stream_in_ready", 32'(in_ready), 32'd1);
                nxt++;
            end else begin
                drive(0, '0, 1, 0);
            end
            if (out_valid) begin
                if (got.size() == 0) first_cyc = c;
                got.push_back(out_data);
            end
        end
        check("stream_latency", 32'(first_cyc), 32'd3);
        check("stream_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size(); i++)
            check("stream_value", 32'(got[i]), 32'(i + 1));

        // Backpressure: 0xA0..0xA3 with output stalled
        bp_words[0] = 8'hA0; bp_words[1] = 8'hA1; bp_words[2] = 8'hA2; bp_words[3] = 8'hA3;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1, bp_words[idx], 0, 0);
            if (c <= 3) check("bp_occupancy", 32'(occupancy), 32'(c));
            check("bp_in_ready", 32'(in_ready), 32'(c < 3));
            if (in_ready) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd3);
        got.delete();
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            drive(idx < 4, bp_words[idx < 4 ? idx : 3], 1, 0);
            if (out_valid) got.push_back(out_data);
            if (idx < 4 && in_ready) idx++;
        end
        check("bp_out_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size(); i++)
            check("bp_out_value", 32'(got[i]), 32'(bp_words[i]));

        // Bubble collapse: build v = 1,0,1 with output stalled
        drive(1, 8'h51, 0, 0);
        drive(0, '0, 0, 0);
        drive(0, '0, 0, 0);
        drive(1, 8'h52, 0, 0);
        drive(1, 8'h53, 0, 0);
        check("bubble_occ_before", 32'(occupancy), 32'd2);
        check("bubble_in_ready", 32'(in_ready), 32'd1);
        drive(0, '0, 0, 0);
        check("bubble_occ_after", 32'(occupancy), 32'd3);
        check("bubble_full_ready", 32'(in_ready), 32'd0);
        check("bubble_out_data", 32'(out_data), 32'h51);
        repeat (5) drive(0, '0, 1, 0);

        // Flush of a full chain
        drive(1, 8'h61, 0, 0);
        drive(1, 8'h62, 0, 0);
        drive(1, 8'h63, 0, 0);
        drive(1, 8'h64, 1, 1);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        drive(0, '0, 0, 0);
        check("flush_occ_after", 32'(occupancy), 32'd0);
        check("flush_ready_after", 32'(in_ready), 32'd1);
        check("flush_data_held", 32'(out_data), 32'h61);

        // Full pass-through
        drive(1, 8'h71, 0, 0);
        drive(1, 8'h72, 0, 0);
        drive(1, 8'h73, 0, 0);
        for (int c = 0; c < 10; c++) begin
            drive(1, WIDTH'(8'h80 + c), 1, 0);
            check("pass_occupancy", 32'(occupancy), 32'd3);
            check("pass_in_ready", 32'(in_ready), 32'd1);
            check("pass_out_data", 32'(out_data), (c < 3) ? 32'(8'h71 + c) : 32'(8'h80 + c - 3));
        end
        repeat (5) drive(0, '0, 1, 0);

        // Asynchronous reset mid-stream with 3 words in flight
        drive(1, 8'h91, 0, 0);
        drive(1, 8'h92, 0, 0);
        drive(1, 8'h93, 0, 0);
        drive(0, '0, 0, 0);
        check("pre_reset_occ", 32'(occupancy), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_occupancy", 32'(occupancy), 32'd0);
        check("async_out_data", 32'(out_data), 32'd0);
        drive(0, '0, 0, 0);
        drive(0, '0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Random traffic; upstream holds a refused word until it is accepted
        pend_v = 1'b0;
        pend   = '0;
        for (int c = 0; c < 800; c++) begin
            logic iv;
            logic fl;
            if (!pend_v) begin
                pend_v = ($urandom_range(0, 3) != 0);
                pend   = WIDTH'($urandom);
            end
            iv = pend_v;
            fl = ($urandom_range(0, 29) == 0);
            drive(iv, iv ? pend : WIDTH'($urandom), ($urandom_range(0, 2) != 0), fl);
            if (iv && in_ready) pend_v = 1'b0;
        end
        repeat (6) drive(0, '0, 1, 0);
        check("drain_occupancy", 32'(occupancy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
